// File: rtl/l1_shared_mem_arbiter.sv
// rtl/l1_shared_mem_arbiter.sv - round-robin arbiter between two L1 caches and one fixed-latency data memory
// Write completions also broadcast an invalidate to the non-owning core's L1.
module l1_shared_mem_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_ack,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_inv,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_ack,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_inv,
    output logic [ADDR_W-1:0] inv_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state_q;
    logic               owner_q;
    logic               rr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         ack_q;
    logic [1:0]         inv_q;
    logic [DATA_W-1:0]  c0_rdata_q;
    logic [DATA_W-1:0]  c1_rdata_q;
    logic [ADDR_W-1:0]  inv_addr_q;
    logic               mem_en_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;

    logic               sel_c1;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    // rr_q names the core that wins a tie; a lone requester always wins.
    assign sel_c1    = (c0_req && c1_req) ? rr_q : c1_req;
    assign sel_we    = sel_c1 ? c1_we    : c0_we;
    assign sel_addr  = sel_c1 ? c1_addr  : c0_addr;
    assign sel_wdata = sel_c1 ? c1_wdata : c0_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
            cnt_q       <= '0;
            ack_q       <= '0;
            inv_q       <= '0;
            c0_rdata_q  <= '0;
            c1_rdata_q  <= '0;
            inv_addr_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (c0_req || c1_req) begin
                        state_q     <= ACCESS;
                        owner_q     <= sel_c1;
                        cnt_q       <= CNT_W'(MEM_LATENCY - 1);
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= sel_we;
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                    end
                end
                ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // The mem_* registers double as the latched request until they clear here.
                        state_q          <= RESP;
                        mem_en_q         <= 1'b0;
                        mem_we_q         <= 1'b0;
                        mem_addr_q       <= '0;
                        mem_wdata_q      <= '0;
                        ack_q[owner_q]   <= 1'b1;
                        inv_q[~owner_q]  <= mem_we_q;
                        inv_addr_q       <= mem_we_q ? mem_addr_q : '0;
                        if (owner_q) c1_rdata_q <= mem_we_q ? '0 : mem_rdata;
                        else         c0_rdata_q <= mem_we_q ? '0 : mem_rdata;
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    rr_q       <= ~owner_q;
                    ack_q      <= '0;
                    inv_q      <= '0;
                    inv_addr_q <= '0;
                    c0_rdata_q <= '0;
                    c1_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign c0_ack    = ack_q[0];
    assign c1_ack    = ack_q[1];
    assign c0_inv    = inv_q[0];
    assign c1_inv    = inv_q[1];
    assign c0_rdata  = c0_rdata_q;
    assign c1_rdata  = c1_rdata_q;
    assign inv_addr  = inv_addr_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    a_one_ack: assert property (@(posedge clk) disable iff (!reset) !(c0_ack && c1_ack));
    a_mem_en_access: assert property (@(posedge clk) disable iff (!reset) mem_en |-> (state_q == ACCESS));
    a_c0_stable: assert property (@(posedge clk) disable iff (!reset)
        (c0_req && !c0_ack) |=> (!c0_req || ($stable(c0_we) && $stable(c0_addr) && $stable(c0_wdata))));
    a_c1_stable: assert property (@(posedge clk) disable iff (!reset)
        (c1_req && !c1_ack) |=> (!c1_req || ($stable(c1_we) && $stable(c1_addr) && $stable(c1_wdata))));

endmodule

// File: tb/tb_l1_shared_mem_arbiter.sv
// tb/tb_l1_shared_mem_arbiter.sv - directed bench for l1_shared_mem_arbiter at MEM_LATENCY 2 and 1
// Instance 0 is built with latency 2, instance 1 with latency 1; each is exercised in turn.
module tb_l1_shared_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n   [2];
    logic        req     [2][2];
    logic        we      [2][2];
    logic [9:0]  addr    [2][2];
    logic [31:0] wdata   [2][2];
    logic        ack     [2][2];
    logic [31:0] rdata   [2][2];
    logic        inv     [2][2];
    logic [9:0]  inv_addr[2];
    logic        mem_en  [2];
    logic        mem_we  [2];
    logic [9:0]  mem_addr[2];
    logic [31:0] mem_wdata[2];
    logic [31:0] mem_rdata[2];

    int n_checks = 0;
    int n_errors = 0;
    int ack_core[$];
    int ack_cyc[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [9:0] a);
        return (a == 10'h005) ? 32'hDEAD_BEEF : ({22'h0, a} ^ 32'hA5A5_0000);
    endfunction

    function automatic int lat(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        l1_shared_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LATENCY((g == 0) ? 2 : 1)) u_dut (
            .clk(clk), .reset(rst_n[g]),
            .c0_req(req[g][0]), .c0_we(we[g][0]), .c0_addr(addr[g][0]), .c0_wdata(wdata[g][0]),
            .c0_ack(ack[g][0]), .c0_rdata(rdata[g][0]), .c0_inv(inv[g][0]),
            .c1_req(req[g][1]), .c1_we(we[g][1]), .c1_addr(addr[g][1]), .c1_wdata(wdata[g][1]),
            .c1_ack(ack[g][1]), .c1_rdata(rdata[g][1]), .c1_inv(inv[g][1]),
            .inv_addr(inv_addr[g]), .mem_en(mem_en[g]), .mem_we(mem_we[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );
        assign mem_rdata[g] = mem_model(mem_addr[g]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input int k, input string tag);
        chk({tag, "_ack"}, {30'h0, ack[k][1], ack[k][0]}, 32'h0);
        chk({tag, "_inv"}, {30'h0, inv[k][1], inv[k][0]}, 32'h0);
        chk({tag, "_mem_en"}, {31'h0, mem_en[k]}, 32'h0);
        chk({tag, "_mem_addr"}, {22'h0, mem_addr[k]}, 32'h0);
        chk({tag, "_rdata"}, rdata[k][0] | rdata[k][1], 32'h0);
    endtask

    task automatic do_reset(input int k);
        for (int c = 0; c < 2; c++) req[k][c] = 1'b0;
        rst_n[k] = 1'b0;
        tick();
        tick();
        rst_n[k] = 1'b1;
        check_quiet(k, "reset");
    endtask

    task automatic single(input int k, input int c, input logic w, input logic [9:0] a, input logic [31:0] d);
        req[k][c] = 1'b1; we[k][c] = w; addr[k][c] = a; wdata[k][c] = d;
        for (int i = 0; i < lat(k); i++) begin
            tick();
            chk("acc_mem_en", {31'h0, mem_en[k]}, 32'h1);
            chk("acc_mem_we", {31'h0, mem_we[k]}, {31'h0, w});
            chk("acc_mem_addr", {22'h0, mem_addr[k]}, {22'h0, a});
            chk("acc_mem_wdata", mem_wdata[k], d);
            chk("acc_no_ack", {31'h0, ack[k][c]}, 32'h0);
        end
        tick();
        chk("resp_ack", {31'h0, ack[k][c]}, 32'h1);
        chk("resp_rdata", rdata[k][c], w ? 32'h0 : mem_model(a));
        chk("resp_inv_other", {31'h0, inv[k][1-c]}, {31'h0, w});
        chk("resp_inv_self", {31'h0, inv[k][c]}, 32'h0);
        chk("resp_inv_addr", {22'h0, inv_addr[k]}, w ? {22'h0, a} : 32'h0);
        chk("resp_mem_en", {31'h0, mem_en[k]}, 32'h0);
        req[k][c] = 1'b0;
        tick();
        check_quiet(k, "after_resp");
    endtask

    task automatic run_traffic(input int k, input int n);
        int sent[2];
        int cyc;
        sent[0] = 0; sent[1] = 0; cyc = 0;
        ack_core.delete(); ack_cyc.delete();
        while (ack_core.size() < 2 * n && cyc < 600) begin
            chk("never_both_ack", {31'h0, ack[k][0] & ack[k][1]}, 32'h0);
            for (int c = 0; c < 2; c++) begin
                if (req[k][c] && ack[k][c]) begin
                    chk("trf_rdata", rdata[k][c], we[k][c] ? 32'h0 : mem_model(addr[k][c]));
                    chk("trf_inv_other", {31'h0, inv[k][1-c]}, {31'h0, we[k][c]});
                    chk("trf_inv_self", {31'h0, inv[k][c]}, 32'h0);
                    if (we[k][c]) chk("trf_inv_addr", {22'h0, inv_addr[k]}, {22'h0, addr[k][c]});
                    ack_core.push_back(c);
                    ack_cyc.push_back(cyc);
                    req[k][c] = 1'b0;
                end else if (!req[k][c] && sent[c] < n) begin
                    req[k][c]   = 1'b1;
                    we[k][c]    = (sent[c] % 2) == 1;
                    addr[k][c]  = 10'(c * 256 + 16 * sent[c] + 16);
                    wdata[k][c] = 32'(32'h1000 * (c + 1) + sent[c]);
                    sent[c]++;
                end
            end
            tick();
            cyc++;
        end
        chk("traffic_done", ack_core.size(), 2 * n);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0;
            for (int c = 0; c < 2; c++) begin
                req[k][c] = 1'b0; we[k][c] = 1'b0; addr[k][c] = '0; wdata[k][c] = '0;
            end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            int c0n;
            do_reset(k);
            single(k, 0, 1'b0, 10'h005, 32'h0000_0055);
            single(k, 1, 1'b1, 10'h3FC, 32'h1234_5678);

            do_reset(k);
            run_traffic(k, 1);
            if (ack_core.size() == 2) begin
                chk("sim_first_c0", ack_core[0], 0);
                chk("sim_second_c1", ack_core[1], 1);
                chk("sim_first_latency", ack_cyc[0], lat(k) + 1);
                chk("sim_spacing", ack_cyc[1] - ack_cyc[0], lat(k) + 2);
            end

            do_reset(k);
            run_traffic(k, 8);
            c0n = 0;
            for (int i = 0; i < ack_core.size(); i++) begin
                chk("alternate", ack_core[i], i % 2);
                if (ack_core[i] == 0) c0n++;
            end
            chk("c0_count", c0n, 8);
            chk("c1_count", ack_core.size() - c0n, 8);

            do_reset(k);
            req[k][0] = 1'b1; we[k][0] = 1'b0; addr[k][0] = 10'h005; wdata[k][0] = '0;
            req[k][1] = 1'b1; we[k][1] = 1'b1; addr[k][1] = 10'h077; wdata[k][1] = 32'h1;
            tick();
            chk("abort_in_access", {31'h0, mem_en[k]}, 32'h1);
            rst_n[k] = 1'b0;
            #1;
            check_quiet(k, "abort_async");
            for (int i = 0; i < lat(k) + 2; i++) begin
                tick();
                check_quiet(k, "abort_hold");
            end
            req[k][0] = 1'b0; req[k][1] = 1'b0;
            rst_n[k] = 1'b1;
            tick();
            check_quiet(k, "abort_released");
            run_traffic(k, 1);
            if (ack_core.size() == 2) chk("abort_regrant_c0", ack_core[0], 0);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
